// File: rtl/mem_read_arbiter_if.sv
// rtl/mem_read_arbiter_if.sv - requester and memory-side signals of the bsram read arbiter
interface mem_read_arbiter_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16
);
    logic                  cp_req;
    logic [ADDR_WIDTH-1:0] cp_addr;
    logic                  cp_gnt;
    logic                  cp_rvalid;
    logic [DATA_WIDTH-1:0] cp_rdata;

    logic                  cpu_req;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport slave (
        input  cp_req, cp_addr, cpu_req, cpu_addr, mem_dout,
        output cp_gnt, cp_rvalid, cp_rdata, cpu_gnt, cpu_rvalid, cpu_rdata, mem_addr
    );

    modport master (
        output cp_req, cp_addr, cpu_req, cpu_addr, mem_dout,
        input  cp_gnt, cp_rvalid, cp_rdata, cpu_gnt, cpu_rvalid, cpu_rdata, mem_addr
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - CP-priority read arbiter for bsram with CPU starvation guard
module mem_read_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WAIT   = 8
) (
    input  logic             clk,
    input  logic             reset,
    mem_read_arbiter_if.slave bus
);
    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    logic [CW-1:0]         wait_cnt;
    logic                  force_cpu;
    logic                  cpu_gnt;
    logic                  cp_gnt;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  cp_rvalid;
    logic                  cpu_rvalid;

    // Grant decision: CP wins unless the CPU has waited MAX_WAIT cycles; nothing granted in reset.
    always_comb begin
        force_cpu = (MAX_WAIT != 0) && bus.cpu_req && (wait_cnt == MAX_CNT);
        cpu_gnt   = reset && bus.cpu_req && (!bus.cp_req || force_cpu);
        cp_gnt    = reset && bus.cp_req && !cpu_gnt;
        addr_sel  = '0;
        if (cp_gnt) begin
            addr_sel = bus.cp_addr;
        end else if (cpu_gnt) begin
            addr_sel = bus.cpu_addr;
        end
    end

    // Count consecutive denied CPU cycles, saturating at MAX_WAIT; any grant or idle cycle clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!bus.cpu_req || cpu_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != MAX_CNT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Owner pipeline: bsram returns data one cycle after it sees the address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cp_rvalid  <= 1'b0;
            cpu_rvalid <= 1'b0;
        end else begin
            cp_rvalid  <= cp_gnt;
            cpu_rvalid <= cpu_gnt;
        end
    end

    assign rdata          = bus.mem_dout;
    assign bus.cp_gnt     = cp_gnt;
    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.mem_addr   = addr_sel;
    assign bus.cp_rvalid  = cp_rvalid;
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.cp_rdata   = rdata;
    assign bus.cpu_rdata  = rdata;
endmodule
